// File: rtl/node_tracker.sv
// node_tracker: fuses line-sensor bits into a debounced node decision,
// counts nodes and drives a steering correction on flagged turn nodes.
module node_tracker #(
  parameter int NUM_SENSORS     = 3,
  parameter int MIN_ACTIVE      = 2,
  parameter int SAMPLE_PERIOD   = 100000,
  parameter int CONFIRM_SAMPLES = 2,
  parameter int RELEASE_SAMPLES = 2,
  parameter int MAX_NODES       = 24,
  parameter int CNT_W           = 6,
  parameter int ERR_W           = 8,
  parameter int TURN_ERR        = -10,
  parameter int WRAP            = 0
) (
  input  logic                    clk_50,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clear,
  input  logic [NUM_SENSORS-1:0]  sensors,
  input  logic [MAX_NODES-1:0]    turn_mask,
  output logic [CNT_W-1:0]        nodes,
  output logic signed [ERR_W-1:0] error,
  output logic                    node_pulse,
  output logic                    on_node
);

  localparam int TW = (SAMPLE_PERIOD > 1) ?
                      $clog2(SAMPLE_PERIOD) : 1;
  localparam int HW = $clog2(CONFIRM_SAMPLES + 1);
  localparam int MW = $clog2(RELEASE_SAMPLES + 1);
  localparam int PW = $clog2(NUM_SENSORS + 1);

  localparam logic [TW-1:0]    T_LAST    = TW'(SAMPLE_PERIOD - 1);
  localparam logic [HW-1:0]    HIT_DONE  = HW'(CONFIRM_SAMPLES);
  localparam logic [MW-1:0]    MISS_DONE = MW'(RELEASE_SAMPLES);
  localparam logic [CNT_W-1:0] NODE_MAX  = CNT_W'(MAX_NODES);
  localparam logic [ERR_W-1:0] TURN_V    = ERR_W'(TURN_ERR);

  typedef enum logic [1:0] {
    SEARCH,
    CONFIRM,
    ON_NODE
  } state_t;

  state_t           state, state_nxt;
  logic [TW-1:0]    timer;
  logic [HW-1:0]    hit, hit_nxt;
  logic [MW-1:0]    miss, miss_nxt;
  logic [PW-1:0]    pop;
  logic [CNT_W-1:0] nodes_nxt;
  logic             det;
  logic             tick;
  logic             reg_node;
  logic             turn_hit;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_SENSORS; i++)
      pop = pop + PW'(sensors[i]);
  end

  assign det  = (pop >= PW'(MIN_ACTIVE));
  assign tick = en && (timer == T_LAST);

  always_comb begin
    state_nxt = state;
    hit_nxt   = hit;
    miss_nxt  = miss;
    reg_node  = 1'b0;
    if (tick) begin
      unique case (state)
        SEARCH: begin
          if (det) begin
            if (CONFIRM_SAMPLES == 1) begin
              reg_node  = 1'b1;
              state_nxt = ON_NODE;
              hit_nxt   = '0;
            end else begin
              hit_nxt   = HW'(1);
              state_nxt = CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (det) begin
            if (hit + HW'(1) == HIT_DONE) begin
              reg_node  = 1'b1;
              state_nxt = ON_NODE;
              hit_nxt   = '0;
            end else begin
              hit_nxt = hit + HW'(1);
            end
          end else begin
            hit_nxt   = '0;
            state_nxt = SEARCH;
          end
        end
        ON_NODE: begin
          if (!det) begin
            if (miss + MW'(1) == MISS_DONE) begin
              miss_nxt  = '0;
              state_nxt = SEARCH;
            end else begin
              miss_nxt = miss + MW'(1);
            end
          end else begin
            miss_nxt = '0;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_comb begin
    nodes_nxt = nodes;
    if (reg_node) begin
      if (nodes == NODE_MAX)
        nodes_nxt = (WRAP == 1) ? CNT_W'(1) : nodes;
      else
        nodes_nxt = nodes + CNT_W'(1);
    end
  end

  // node k maps to mask bit k-1; node 0 shifts the bit out entirely
  assign turn_hit =
    |(turn_mask & (MAX_NODES'(1) << (nodes_nxt - CNT_W'(1))));

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEARCH;
      timer      <= '0;
      hit        <= '0;
      miss       <= '0;
      nodes      <= '0;
      error      <= '0;
      node_pulse <= 1'b0;
      on_node    <= 1'b0;
    end else if (clear) begin
      state      <= SEARCH;
      timer      <= '0;
      hit        <= '0;
      miss       <= '0;
      nodes      <= '0;
      error      <= '0;
      node_pulse <= 1'b0;
      on_node    <= 1'b0;
    end else if (en) begin
      timer      <= tick ? '0 : timer + TW'(1);
      state      <= state_nxt;
      hit        <= hit_nxt;
      miss       <= miss_nxt;
      nodes      <= nodes_nxt;
      node_pulse <= reg_node;
      on_node    <= (state_nxt == ON_NODE);
      error      <= (state_nxt == ON_NODE && turn_hit) ?
                    TURN_V : '0;
    end else begin
      node_pulse <= 1'b0;
    end
  end

endmodule

// File: tb/tb_node_tracker.sv
// Directed bench for node_tracker: saturating and wrapping instances
// share one stimulus stream.
module tb_node_tracker;

  logic       clk_50 = 1'b0;
  logic       rst_n;
  logic       en;
  logic       clear;
  logic [2:0] sensors;
  logic [4:0] turn_mask;

  logic [2:0] nodes_s, nodes_w;
  logic [7:0] err_s, err_w;
  logic       pul_s, pul_w;
  logic       on_s, on_w;

  int errors = 0;
  int checks = 0;
  int pcs = 0;
  int pcw = 0;
  int es, ew;

  always #5 clk_50 = ~clk_50;

  node_tracker #(
    .NUM_SENSORS(3), .MIN_ACTIVE(2), .SAMPLE_PERIOD(4),
    .CONFIRM_SAMPLES(2), .RELEASE_SAMPLES(2), .MAX_NODES(5),
    .CNT_W(3), .ERR_W(8), .TURN_ERR(-10), .WRAP(0)
  ) u_sat (
    .clk_50(clk_50), .rst_n(rst_n), .en(en), .clear(clear),
    .sensors(sensors), .turn_mask(turn_mask),
    .nodes(nodes_s), .error(err_s),
    .node_pulse(pul_s), .on_node(on_s)
  );

  node_tracker #(
    .NUM_SENSORS(3), .MIN_ACTIVE(2), .SAMPLE_PERIOD(4),
    .CONFIRM_SAMPLES(2), .RELEASE_SAMPLES(2), .MAX_NODES(5),
    .CNT_W(3), .ERR_W(8), .TURN_ERR(-10), .WRAP(1)
  ) u_wrap (
    .clk_50(clk_50), .rst_n(rst_n), .en(en), .clear(clear),
    .sensors(sensors), .turn_mask(turn_mask),
    .nodes(nodes_w), .error(err_w),
    .node_pulse(pul_w), .on_node(on_w)
  );

  always @(posedge clk_50) begin
    if (pul_s) pcs++;
    if (pul_w) pcw++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_50);
    @(negedge clk_50);
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b1;
    clear     = 1'b0;
    sensors   = 3'b000;
    turn_mask = 5'b01000;
    step(2);
    chk("rst_nodes", {29'd0, nodes_s}, 32'd0);
    chk("rst_err", {24'd0, err_s}, 32'd0);
    chk("rst_on", {31'd0, on_s}, 32'd0);
    chk("rst_pulse", {31'd0, pul_s}, 32'd0);

    // first node from reset
    sensors = 3'b111;
    rst_n   = 1'b1;
    step(7);
    chk("t1_early_nodes", {29'd0, nodes_s}, 32'd0);
    chk("t1_early_pulse", {31'd0, pul_s}, 32'd0);
    step(1);
    chk("t1_pulse", {31'd0, pul_s}, 32'd1);
    chk("t1_nodes", {29'd0, nodes_s}, 32'd1);
    chk("t1_on", {31'd0, on_s}, 32'd1);
    chk("t1_err", {24'd0, err_s}, 32'd0);
    step(1);
    chk("t1_pulse_end", {31'd0, pul_s}, 32'd0);

    // single low tick keeps on_node, two release it
    sensors = 3'b000;
    step(3);
    chk("t5_miss1_on", {31'd0, on_s}, 32'd1);
    sensors = 3'b111;
    step(4);
    sensors = 3'b000;
    step(4);
    chk("t5_missreset_on", {31'd0, on_s}, 32'd1);
    step(4);
    chk("t5_release_on", {31'd0, on_s}, 32'd0);
    chk("t5_nodes", {29'd0, nodes_s}, 32'd1);

    // one-tick glitch must not count
    sensors = 3'b011;
    step(4);
    chk("t2_confirm_on", {31'd0, on_s}, 32'd0);
    sensors = 3'b001;
    step(4);
    sensors = 3'b011;
    step(4);
    chk("t2_pulse", {31'd0, pul_s}, 32'd0);
    chk("t2_nodes", {29'd0, nodes_s}, 32'd1);
    sensors = 3'b001;
    step(4);
    chk("t2_nodes_end", {29'd0, nodes_s}, 32'd1);

    // passes 2..7: turn error on node 4, saturate vs wrap
    for (int p = 2; p <= 7; p++) begin
      es = (p > 5) ? 5 : p;
      ew = (p > 5) ? p - 5 : p;
      sensors = 3'b111;
      step(8);
      chk("pass_pulse_s", {31'd0, pul_s}, 32'd1);
      chk("pass_pulse_w", {31'd0, pul_w}, 32'd1);
      chk("pass_nodes_s", {29'd0, nodes_s}, es);
      chk("pass_nodes_w", {29'd0, nodes_w}, ew);
      chk("pass_on", {31'd0, on_s}, 32'd1);
      chk("pass_err_s", {24'd0, err_s},
          (es == 4) ? 32'hF6 : 32'd0);
      chk("pass_err_w", {24'd0, err_w},
          (ew == 4) ? 32'hF6 : 32'd0);
      if (p == 4) begin
        turn_mask = 5'b00000;
        step(1);
        chk("mask_off_err", {24'd0, err_s}, 32'd0);
        turn_mask = 5'b01000;
        step(1);
        chk("mask_on_err", {24'd0, err_s}, 32'hF6);
        sensors = 3'b000;
        step(6);
      end else begin
        sensors = 3'b000;
        step(8);
      end
      chk("pass_off_on", {31'd0, on_s}, 32'd0);
      chk("pass_off_err", {24'd0, err_s}, 32'd0);
    end
    chk("pulse_count_s", pcs, 32'd7);
    chk("pulse_count_w", pcw, 32'd7);

    // asynchronous reset mid-confirm
    sensors = 3'b111;
    step(4);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_nodes_s", {29'd0, nodes_s}, 32'd0);
    chk("arst_nodes_w", {29'd0, nodes_w}, 32'd0);
    chk("arst_on", {31'd0, on_s}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(4);
    chk("arst_hit_gone_nodes", {29'd0, nodes_s}, 32'd0);
    chk("arst_hit_gone_on", {31'd0, on_s}, 32'd0);
    step(4);
    chk("arst_reconf_nodes", {29'd0, nodes_s}, 32'd1);

    // reach node 3 on a turn, then clear with en low
    sensors = 3'b000;
    step(8);
    sensors = 3'b111;
    step(8);
    sensors = 3'b000;
    step(8);
    sensors = 3'b111;
    step(8);
    chk("pre_clear_nodes", {29'd0, nodes_s}, 32'd3);
    turn_mask = 5'b00100;
    step(1);
    chk("pre_clear_err", {24'd0, err_s}, 32'hF6);
    en    = 1'b0;
    clear = 1'b1;
    step(1);
    chk("clr_nodes", {29'd0, nodes_s}, 32'd0);
    chk("clr_err", {24'd0, err_s}, 32'd0);
    chk("clr_on", {31'd0, on_s}, 32'd0);
    clear = 1'b0;
    en    = 1'b1;
    step(7);
    chk("clr_timer_nodes", {29'd0, nodes_s}, 32'd0);
    step(1);
    chk("clr_refind_nodes", {29'd0, nodes_s}, 32'd1);
    chk("clr_refind_pulse", {31'd0, pul_s}, 32'd1);

    // en low freezes everything while sensors move
    en = 1'b0;
    for (int i = 0; i < 22; i++) begin
      sensors = 3'(i);
      step(1);
    end
    chk("frz_nodes", {29'd0, nodes_s}, 32'd1);
    chk("frz_on", {31'd0, on_s}, 32'd1);
    chk("frz_pulse", {31'd0, pul_s}, 32'd0);
    en      = 1'b1;
    sensors = 3'b000;
    step(5);
    chk("frz_timer_on", {31'd0, on_s}, 32'd1);
    step(3);
    chk("frz_release_on", {31'd0, on_s}, 32'd0);
    chk("frz_final_nodes", {29'd0, nodes_s}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
